spin_readout: RTL and testbench
===============================

SPIN_READOUT -- requirements
Module: spin_readout

Interface
REQ-001 SHALL have parameter N, default 3: number of oscillators sampled; osc_in[0] is the phase reference.
REQ-002 SHALL have parameter SETTLE, default 4: clock cycles discarded after start, before counting.
REQ-003 SHALL have parameter WINDOW, default 64, even and >= 2: number of sample cycles per measurement.
REQ-004 SHALL have parameter MARGIN, default 8: ambiguity band half-width, in samples.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port osc_in, input, N: free-running oscillator outputs, asynchronous to clk.
REQ-008 SHALL have port start, input, 1: measurement request, sampled only in IDLE.
REQ-009 SHALL have port busy, output, 1: high in SETTLE, SAMPLE and DONE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when spins/ambiguous are updated.
REQ-011 SHALL have port spins, output, N: 1 = in phase with reference, 0 = anti-phase; held until the next done.
REQ-012 SHALL have port ambiguous, output, N: 1 = match count within MARGIN of WINDOW/2; held with spins.

Function
REQ-013 SHALL pass each osc_in bit through a two-flop synchronizer; all logic uses only the synchronized value s[i].
REQ-014 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 SHALL go IDLE->SETTLE on a clock edge with start=1; start in any other state SHALL be ignored, not queued.
REQ-016 SHALL stay in SETTLE exactly SETTLE cycles, then enter SAMPLE; SETTLE=0 SHALL go directly to SAMPLE.
REQ-017 SHALL clear all match counters on SAMPLE entry.
REQ-018 SHALL, in each SAMPLE cycle, increment match[i] when s[i]==s[0], for i in 0..N-1.
REQ-019 SHALL size counters to clog2(WINDOW+1) bits; counters cannot overflow, since the maximum count is WINDOW.
REQ-020 SHALL stay in SAMPLE exactly WINDOW cycles, then enter DONE.
REQ-021 SHALL, in DONE, register spins[i] = (match[i] >= WINDOW/2), so a tie resolves to 1.
REQ-022 SHALL, in DONE, register ambiguous[i] = (|match[i] - WINDOW/2| < MARGIN).
REQ-023 SHALL assert done for exactly the DONE cycle, then return to IDLE.
REQ-024 SHALL give latency from the start-accept edge to the done cycle of exactly SETTLE+WINDOW+1 cycles.
REQ-025 SHALL force spins[0]=1 and ambiguous[0]=0, since the reference always matches itself.
REQ-026 SHALL allow start to be re-accepted on the first IDLE cycle after DONE.

Reset
REQ-027 SHALL, while rst is high, force state=IDLE, busy=0, done=0, spins=0, ambiguous=0, counters=0 and synchronizer flops=0, asynchronously.
REQ-028 SHALL abort any measurement in progress on rst; no done pulse is produced for it.
REQ-029 SHALL produce its first valid measurement only from a start accepted after rst deasserts.

Structure
REQ-030 SHALL place the state encoding and the default SETTLE/WINDOW/MARGIN constants in the shared Ising package.
REQ-031 SHALL use one sub-module, sync_2ff (1-bit, clk/rst, async-high reset), instantiated N times.
REQ-032 SHALL keep per-oscillator counters and decision logic in a generate loop within spin_readout.

Verification (N=3, SETTLE=4, WINDOW=64, MARGIN=8)
REQ-033 SHALL check: osc_in held at 3'b000, start pulsed -> done exactly 69 cycles after the accept edge, spins=3'b111, ambiguous=3'b000.
REQ-034 SHALL check: osc_in[0] toggles every 5 clk, osc_in[1]=~osc_in[0], osc_in[2]=osc_in[0] -> spins=3'b101, ambiguous=3'b000.
REQ-035 SHALL check: osc_in[2] forced to match the reference in exactly 32 of 64 synchronized samples -> spins[2]=1, ambiguous[2]=1; with 45 matches -> spins[2]=1, ambiguous[2]=0; with 20 matches -> spins[2]=0, ambiguous[2]=0.
REQ-036 SHALL check: rst pulsed during SAMPLE cycle 30 -> busy=0 and spins=0 immediately, no done pulse; the next start yields a normal result at 69 cycles.
REQ-037 SHALL check: start held high for 100 cycles -> exactly one done; a second done appears 70 cycles after the first, as start is re-accepted in the first IDLE cycle.
REQ-038 SHALL check: two coupled oscillator instances (reference plus one coupled node), rst pulsed, then start -> spins[1] matches the phase relation predicted from the coupling weight sign.

Source files
------------

// File: rtl/spin_readout_pkg.sv
// -----------------------------------------------------------------------------
// spin_readout_pkg
// Shared Ising readout package: the measurement FSM state encoding, the
// default measurement constants and a small distance helper used by the
// ambiguity decision.
// -----------------------------------------------------------------------------
package spin_readout_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Default measurement constants
    localparam int DEF_N      = 3;
    localparam int DEF_SETTLE = 4;
    localparam int DEF_WINDOW = 64;
    localparam int DEF_MARGIN = 8;

    // Absolute distance between two non-negative counts
    function automatic int abs_diff(input int a, input int b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

endpackage

// File: rtl/spin_readout_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer bringing a free-running oscillator output
// into the clk domain.
// Ports:
//   clk - sampling clock, rising edge
//   rst - asynchronous active-high reset, clears both flops
//   d   - asynchronous input bit
//   q   - synchronized output bit
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/spin_readout.sv
// -----------------------------------------------------------------------------
// spin_readout
// Reads the phase state of N coupled oscillators. After a start request the
// block waits SETTLE cycles, then counts over WINDOW cycles how often each
// synchronized oscillator agrees with the reference osc_in[0]. A majority of
// agreements reads as spin 1 (in phase), otherwise spin 0 (anti-phase); counts
// close to WINDOW/2 are flagged as ambiguous.
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-high reset, aborts any measurement
//   osc_in    - N oscillator outputs, asynchronous to clk; bit 0 is reference
//   start     - measurement request, only looked at while idle
//   busy      - high from start accept through the done cycle
//   done      - one-cycle pulse when spins/ambiguous are refreshed
//   spins     - 1 = in phase with reference, 0 = anti-phase
//   ambiguous - 1 = agreement count within MARGIN of WINDOW/2
// -----------------------------------------------------------------------------
module spin_readout
    import spin_readout_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int SETTLE = DEF_SETTLE,
    parameter int WINDOW = DEF_WINDOW,
    parameter int MARGIN = DEF_MARGIN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] osc_in,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] spins,
    output logic [N-1:0] ambiguous
);

    // Match counters never exceed WINDOW
    localparam int CW   = $clog2(WINDOW + 1);
    // Phase timer covers the longer of the settle and sample phases
    localparam int TMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int HALF = WINDOW / 2;
    // The reference always agrees with itself, so its result is fixed
    localparam logic [N-1:0] REF_MASK = N'(1);

    state_e         state_r;
    state_e         state_nxt_s;
    logic [TW-1:0]  tmr_r;
    logic [N-1:0]   s_s;
    logic [N-1:0]   spin_dec_s;
    logic [N-1:0]   amb_dec_s;
    logic           busy_nxt_s;
    logic           done_nxt_s;
    logic           sample_entry_s;
    logic           busy_r;
    logic           done_r;
    logic [N-1:0]   spins_r;
    logic [N-1:0]   amb_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero settle time skips straight to sampling
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_r == TW'(SETTLE - 1)) begin
                    state_nxt_s = ST_SAMPLE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (tmr_r == TW'(WINDOW - 1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SAMPLE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so busy/done can be registered
    always_comb begin
        busy_nxt_s     = 1'b0;
        done_nxt_s     = 1'b0;
        sample_entry_s = 1'b0;
        if (state_nxt_s != ST_IDLE) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
        if (state_nxt_s == ST_DONE) begin
            done_nxt_s = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end
        if ((state_nxt_s == ST_SAMPLE) && (state_r != ST_SAMPLE)) begin
            sample_entry_s = 1'b1;
        end else begin
            sample_entry_s = 1'b0;
        end
    end

    // Phase timer: restarts at every state change, runs in SETTLE and SAMPLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_r <= '0;
        end else if (state_nxt_s != state_r) begin
            tmr_r <= '0;
        end else if ((state_r == ST_SETTLE) || (state_r == ST_SAMPLE)) begin
            tmr_r <= tmr_r + TW'(1);
        end else begin
            tmr_r <= '0;
        end
    end

    // Per-oscillator synchronizer, agreement counter and decision
    for (genvar gi = 0; gi < N; gi++) begin : g_osc
        logic [CW-1:0] match_r;
        logic [CW-1:0] match_inc_s;
        logic          hit_s;

        sync_2ff u_sync (
            .clk (clk),
            .rst (rst),
            .d   (osc_in[gi]),
            .q   (s_s[gi])
        );

        // Count including the current sample, so the last SAMPLE cycle is
        // already part of the decision registered on the DONE entry edge
        always_comb begin
            hit_s       = (s_s[gi] == s_s[0]);
            match_inc_s = match_r + {{(CW-1){1'b0}}, hit_s};
        end

        // Agreement counter: cleared on SAMPLE entry, counts during SAMPLE
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                match_r <= '0;
            end else if (sample_entry_s) begin
                match_r <= '0;
            end else if (state_r == ST_SAMPLE) begin
                match_r <= match_inc_s;
            end else begin
                match_r <= match_r;
            end
        end

        // Ties resolve to in-phase
        assign spin_dec_s[gi] = (int'(match_inc_s) >= HALF);
        assign amb_dec_s[gi]  = (abs_diff(int'(match_inc_s), HALF) < MARGIN);
    end

    // Registered outputs; results load together with the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            spins_r <= '0;
            amb_r   <= '0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (done_nxt_s) begin
                spins_r <= spin_dec_s | REF_MASK;
                amb_r   <= amb_dec_s & ~REF_MASK;
            end else begin
                spins_r <= spins_r;
                amb_r   <= amb_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign spins     = spins_r;
    assign ambiguous = amb_r;

endmodule

// File: tb/tb_spin_readout.sv
// -----------------------------------------------------------------------------
// tb_spin_readout
// Directed bench for spin_readout with N=3, SETTLE=4, WINDOW=64, MARGIN=8.
// Cycle c=1 is the cycle right after the start-accept edge; the done pulse is
// expected in cycle 69 (SETTLE + WINDOW + 1).
// -----------------------------------------------------------------------------
module tb_spin_readout;

    logic       clk;
    logic       rst;
    logic [2:0] osc_in;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] spins;
    logic [2:0] ambiguous;

    logic [2:0] osc_drv;
    logic       cpl_en;
    logic       ref_osc;
    logic       node_osc;
    logic       cpl_anti;
    int         lag_ns;
    int         cpl_weight;

    int         checks_cnt;
    int         fail_cnt;

    logic [2:0] sp;
    logic [2:0] am;

    spin_readout #(
        .N      (3),
        .SETTLE (4),
        .WINDOW (64),
        .MARGIN (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .osc_in    (osc_in),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .spins     (spins),
        .ambiguous (ambiguous)
    );

    assign osc_in = cpl_en ? {osc_drv[2], node_osc, ref_osc} : osc_drv;

    // Clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference oscillator, half-period 23, unrelated to clk
    initial begin
        ref_osc = 1'b0;
        forever #23 ref_osc = ~ref_osc;
    end

    // Coupled node: follows the reference (or its inverse for negative
    // coupling) with a lag that shrinks as the pair locks
    always @(ref_osc) begin
        #(lag_ns);
        node_osc = ref_osc ^ cpl_anti;
        if (lag_ns > 1) lag_ns = lag_ns - 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One measurement. mode 0: all low; 1: ref toggles every 5 clk with
    // osc1 inverted and osc2 equal; 2: osc2 leaves the reference after k
    // matching samples; 3: osc_in left to the coupled model.
    task automatic run_meas(input string tag, input int mode, input int k,
                            output logic [2:0] res_sp, output logic [2:0] res_am);
        int done_cyc;
        int n_done;
        done_cyc = -1;
        n_done   = 0;
        res_sp   = 3'b000;
        res_am   = 3'b000;
        if (mode == 1) osc_drv = 3'b010;
        else if (mode != 3) osc_drv = 3'b000;
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (mode == 1) begin
                osc_drv[0] = (((c - 1) / 5) % 2) == 1;
                osc_drv[1] = ~osc_drv[0];
                osc_drv[2] = osc_drv[0];
            end
            // Change after edge j first reaches the count at edge j+3
            if ((mode == 2) && (c - 1 == k + 2)) osc_drv[2] = 1'b1;
            if (done === 1'b1) begin
                n_done++;
                done_cyc = c;
                res_sp   = spins;
                res_am   = ambiguous;
            end
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_done_count"}, n_done, 1);
        check_eq({tag, "_latency"}, done_cyc, 69);
    endtask

    initial begin
        int n_done;
        int n_hold;
        int first_cyc;
        int second_cyc;
        checks_cnt = 0;
        fail_cnt   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        osc_drv    = 3'b000;
        cpl_en     = 1'b0;
        cpl_anti   = 1'b0;
        lag_ns     = 15;
        node_osc   = 1'b0;
        cpl_weight = 1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_spins", spins, 0);
        check_eq("reset_amb", ambiguous, 0);
        rst = 1'b0;

        // All oscillators low: everything agrees
        run_meas("all_low", 0, 0, sp, am);
        check_eq("all_low_spins", sp, 3'b111);
        check_eq("all_low_amb", am, 3'b000);

        // Toggling reference, node 1 anti-phase, node 2 in phase
        run_meas("toggle", 1, 0, sp, am);
        check_eq("toggle_spins", sp, 3'b101);
        check_eq("toggle_amb", am, 3'b000);

        // Exactly half agreement: tie reads in phase and ambiguous
        run_meas("m32", 2, 32, sp, am);
        check_eq("m32_spin2", sp[2], 1);
        check_eq("m32_amb2", am[2], 1);

        // 20 agreements: clearly anti-phase
        run_meas("m20", 2, 20, sp, am);
        check_eq("m20_spin2", sp[2], 0);
        check_eq("m20_amb2", am[2], 0);

        // 45 agreements: clearly in phase
        run_meas("m45", 2, 45, sp, am);
        check_eq("m45_spin2", sp[2], 1);
        check_eq("m45_amb2", am[2], 0);
        check_eq("m45_spins_held", spins, 3'b111);

        // Reset during SAMPLE cycle 30 (cycle 34 after accept)
        osc_drv = 3'b000;
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        check_eq("abort_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_spins", spins, 0);
        check_eq("abort_amb", ambiguous, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 80; c++) begin
            if (done === 1'b1) n_done++;
            @(posedge clk);
            #1;
        end
        check_eq("abort_no_done", n_done, 0);
        run_meas("after_abort", 0, 0, sp, am);
        check_eq("after_abort_spins", sp, 3'b111);
        check_eq("after_abort_amb", am, 3'b000);

        // Start held for 100 cycles: one done inside, re-accept right after
        osc_drv = 3'b000;
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1;
        n_done     = 0;
        n_hold     = 0;
        first_cyc  = -1;
        second_cyc = -1;
        for (int c = 1; c <= 170; c++) begin
            if (c == 101) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (c <= 100) n_hold++;
                if (first_cyc < 0) first_cyc = c;
                else second_cyc = c;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check_eq("hold_done_in_hold", n_hold, 1);
        check_eq("hold_done_total", n_done, 2);
        check_eq("hold_first_latency", first_cyc, 69);
        check_eq("hold_gap", second_cyc - first_cyc, 70);

        // Coupled pair, positive then negative coupling weight
        cpl_en = 1'b1;
        for (int w = 0; w < 2; w++) begin
            cpl_weight = (w == 0) ? 1 : -1;
            cpl_anti   = (cpl_weight < 0);
            lag_ns     = 15;
            #1 rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            repeat (40) @(posedge clk);
            run_meas((w == 0) ? "cpl_pos" : "cpl_neg", 3, 0, sp, am);
            check_eq((w == 0) ? "cpl_pos_spin0" : "cpl_neg_spin0", sp[0], 1);
            check_eq((w == 0) ? "cpl_pos_spin1" : "cpl_neg_spin1", sp[1], (cpl_weight > 0) ? 1 : 0);
            check_eq((w == 0) ? "cpl_pos_amb1" : "cpl_neg_amb1", am[1], 0);
        end
        cpl_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
